// File: rtl/ascon_out_serializer.sv
// ----------------------------------------------------------------------------
// ascon_out_serializer
//
// Sits after the Ascon permutation core. On the rising edge of rounds_done
// it snapshots the first NUM_WORDS state words (S_0 first) and streams them
// out one byte at a time over a valid/ready port, MSB byte of each word
// first. This is the path by which hash digests and tags leave the chip.
//
// Optional feature (compile-time macro ASCON_SER_XOR_CHK_EN):
//   When defined, one extra byte follows the data bytes, carrying the XOR of
//   all data bytes; out_last then marks that checksum byte.
//   When undefined, the frame is exactly 8*NUM_WORDS bytes.
//
// Parameters
//   NUM_WORDS    number of 64-bit state words sent (1..5)
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   rounds_done  permutation finished (level; only its rising edge is used)
//   s0_in..s4_in permutation state words S_0..S_4
//   clear        synchronous abort / re-arm (wins over a same-cycle capture)
//   out_data     current byte
//   out_valid    out_data is valid
//   out_ready    sink accepts the current byte
//   out_last     final byte of the frame (qualified by out_valid)
//   busy         a frame is being streamed
//   done         frame fully sent; sticky until clear or next capture
//   overrun      rounds_done rose while streaming; sticky until clear
// ----------------------------------------------------------------------------
module ascon_out_serializer #(
    parameter int NUM_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rounds_done,
    input  logic [63:0] s0_in,
    input  logic [63:0] s1_in,
    input  logic [63:0] s2_in,
    input  logic [63:0] s3_in,
    input  logic [63:0] s4_in,
    input  logic        clear,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam int DATA_BYTES = 8 * NUM_WORDS;
`ifdef ASCON_SER_XOR_CHK_EN
    localparam int FL = DATA_BYTES + 1;
`else
    localparam int FL = DATA_BYTES;
`endif
    localparam int CW = $clog2(FL + 1);
    localparam int BW = 64 * NUM_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t          state;
    logic            rd_q;
    logic            rise;
    logic [BW-1:0]   data_q;
    logic [CW-1:0]   cnt;
    logic [319:0]    all_words;
    logic [BW-1:0]   capture;
    logic            unused_words;
`ifdef ASCON_SER_XOR_CHK_EN
    logic [7:0]      xor_acc;
`endif

    assign rise      = rounds_done & ~rd_q;
    assign all_words = {s0_in, s1_in, s2_in, s3_in, s4_in};
    // S_0 sits at the top so that it is the first word shifted out.
    assign capture   = all_words[319 -: BW];
    // Words beyond NUM_WORDS are intentionally not captured.
    assign unused_words = ^all_words;

    // The byte on the wire is always the top byte of the shift buffer.
    assign out_data  = data_q[BW-1 -: 8];
    assign busy      = (state == ST_SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_q      <= 1'b0;
            data_q    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
`ifdef ASCON_SER_XOR_CHK_EN
            xor_acc   <= '0;
`endif
        end else begin
            rd_q <= rounds_done;
            if (clear) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (rise) begin
                            data_q    <= capture;
                            cnt       <= '0;
                            done      <= 1'b0;
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                            state     <= ST_SEND;
`ifdef ASCON_SER_XOR_CHK_EN
                            xor_acc   <= '0;
`endif
                        end
                    end
                    ST_SEND: begin
                        // A new result arriving mid-frame is dropped, not queued.
                        if (rise) overrun <= 1'b1;
                        if (out_ready) begin
                            cnt <= cnt + CW'(1);
                            if (out_last) begin
                                state     <= ST_DONE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                done      <= 1'b1;
                                data_q    <= data_q << 8;
                            end else begin
                                // out_last is registered one transfer ahead.
                                out_last <= (cnt == CW'(FL - 2));
`ifdef ASCON_SER_XOR_CHK_EN
                                xor_acc <= xor_acc ^ out_data;
                                // After the final data byte, the checksum
                                // becomes the next byte on the wire.
                                if (cnt == CW'(DATA_BYTES - 1))
                                    data_q <= {xor_acc ^ out_data, {(BW-8){1'b0}}};
                                else
                                    data_q <= data_q << 8;
`else
                                data_q <= data_q << 8;
`endif
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
